// File: rtl/preamble_peak_detector_pkg.sv
// Shared types and width helpers for the preamble detection path.
// The width helpers are also used by the correlator bank, so both sides agree on port sizes.
package preamble_peak_detector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_TRACK = 2'd2,
        ST_HOLD  = 2'd3
    } det_state_t;

    // Score width needed to hold a full-match count of 0..length.
    function automatic int corr_width_of(input int length);
        return $clog2(length + 1);
    endfunction

    function automatic int bank_w_of(input int banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

    // Width of a counter that runs 0..n-1 without wrapping.
    function automatic int cnt_w_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/preamble_peak_detector_argmax.sv
// Registered argmax over the correlator banks; latency 1, lowest bank index wins ties.
// Implemented as a balanced compare tree padded to a power of two.
module bank_argmax
    import preamble_peak_detector_pkg::*;
#(
    parameter int BANKS      = 16,
    parameter int CORR_WIDTH = 7,
    localparam int BANK_W    = bank_w_of(BANKS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CORR_WIDTH*BANKS-1:0]  corr_dat,
    input  logic                         corr_vld,
    output logic [CORR_WIDTH-1:0]        best_score,
    output logic [BANK_W-1:0]            best_bank,
    output logic                         best_vld
);

    localparam int NP = 1 << BANK_W;

    typedef struct packed {
        logic [BANK_W-1:0]     bank;
        logic [CORR_WIDTH-1:0] score;
    } cand_t;

    // Left child always covers lower indices, so a strict compare keeps the lowest bank on ties.
    // Padding leaves score 0 at higher indices and therefore never beat a real bank.
    function automatic cand_t tree_max(input logic [CORR_WIDTH*BANKS-1:0] dat);
        logic [CORR_WIDTH*NP-1:0] padded;
        cand_t                    node [1:2*NP-1];
        padded = '0;
        padded[CORR_WIDTH*BANKS-1:0] = dat;
        for (int i = 0; i < NP; i++) begin
            node[NP+i].bank  = BANK_W'(i);
            node[NP+i].score = padded[i*CORR_WIDTH +: CORR_WIDTH];
        end
        for (int k = NP - 1; k >= 1; k--) begin
            node[k] = (node[2*k+1].score > node[2*k].score) ? node[2*k+1] : node[2*k];
        end
        return node[1];
    endfunction

    cand_t win;

    assign win = tree_max(corr_dat);

    always_ff @(posedge clk) begin
        if (rst) begin
            best_vld   <= 1'b0;
            best_score <= '0;
            best_bank  <= '0;
        end else begin
            best_vld <= corr_vld;
            if (corr_vld) begin
                best_score <= win.score;
                best_bank  <= win.bank;
            end
        end
    end

endmodule

// File: rtl/preamble_peak_detector.sv
// Preamble peak detector: picks the best correlator bank per sample, confirms a peak
// after PEAK_WINDOW non-improving samples, then holds off before re-arming.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | disarmed; waits for a quiet (all_zeros) valid sample
//   ST_ARMED | quiet seen; waits for a score >= THRESHOLD
//   ST_TRACK | following the peak; counts non-improving samples
//   ST_HOLD  | detection issued; ignores HOLDOFF valid samples
module preamble_peak_detector
    import preamble_peak_detector_pkg::*;
#(
    parameter int LENGTH      = 64,
    parameter int BANKS       = 16,
    parameter int THRESHOLD   = 52,
    parameter int PEAK_WINDOW = 8,
    parameter int HOLDOFF     = 256,
    localparam int CORR_WIDTH = corr_width_of(LENGTH),
    localparam int BANK_W     = bank_w_of(BANKS),
    localparam int OFF_W      = $clog2(PEAK_WINDOW + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [CORR_WIDTH*BANKS-1:0]  corr_dat,
    input  logic                         corr_vld,
    input  logic                         all_zeros,
    output logic                         det_vld,
    output logic [BANK_W-1:0]            det_bank,
    output logic [CORR_WIDTH-1:0]        det_score,
    output logic [OFF_W-1:0]             det_offset,
    output logic                         busy
);

    localparam int SP_W = cnt_w_of(PEAK_WINDOW);
    localparam int HC_W = cnt_w_of(HOLDOFF);

    localparam logic [CORR_WIDTH-1:0] THR_SCORE = CORR_WIDTH'(THRESHOLD);
    localparam logic [SP_W-1:0]       SP_LAST   = SP_W'(PEAK_WINDOW - 1);
    localparam logic [HC_W-1:0]       HC_LAST   = HC_W'(HOLDOFF - 1);
    localparam logic [OFF_W-1:0]      OFF_VAL   = OFF_W'(PEAK_WINDOW);

    logic [CORR_WIDTH-1:0] best_score;
    logic [BANK_W-1:0]     best_bank;
    logic                  best_vld;

    det_state_t            state;
    logic [CORR_WIDTH-1:0] peak_score;
    logic [BANK_W-1:0]     peak_bank;
    logic [SP_W-1:0]       since_peak;
    logic [HC_W-1:0]       hold_cnt;

    bank_argmax #(
        .BANKS      (BANKS),
        .CORR_WIDTH (CORR_WIDTH)
    ) u_argmax (
        .clk        (clk),
        .rst        (rst),
        .corr_dat   (corr_dat),
        .corr_vld   (corr_vld),
        .best_score (best_score),
        .best_bank  (best_bank),
        .best_vld   (best_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            peak_score <= '0;
            peak_bank  <= '0;
            since_peak <= '0;
            hold_cnt   <= '0;
            det_vld    <= 1'b0;
            det_bank   <= '0;
            det_score  <= '0;
            det_offset <= '0;
        end else begin
            det_vld <= 1'b0;
            // Disable wins over everything, including a detection confirmed this cycle.
            if (!en) begin
                state      <= ST_IDLE;
                peak_score <= '0;
                peak_bank  <= '0;
                since_peak <= '0;
                hold_cnt   <= '0;
            end else if (best_vld) begin
                case (state)
                    ST_IDLE: begin
                        if (all_zeros) begin
                            state <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (best_score >= THR_SCORE) begin
                            state      <= ST_TRACK;
                            peak_score <= best_score;
                            peak_bank  <= best_bank;
                            since_peak <= '0;
                        end
                    end
                    ST_TRACK: begin
                        if (best_score > peak_score) begin
                            peak_score <= best_score;
                            peak_bank  <= best_bank;
                            since_peak <= '0;
                        end else if (since_peak == SP_LAST) begin
                            det_vld    <= 1'b1;
                            det_bank   <= peak_bank;
                            det_score  <= peak_score;
                            det_offset <= OFF_VAL;
                            state      <= ST_HOLD;
                            hold_cnt   <= '0;
                        end else begin
                            since_peak <= since_peak + 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (hold_cnt == HC_LAST) begin
                            state    <= ST_IDLE;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy = (state == ST_TRACK) || (state == ST_HOLD);

endmodule

// File: tb/tb_preamble_peak_detector.sv
// Directed bench for preamble_peak_detector with 4 banks, window 4, holdoff 8.
module tb_preamble_peak_detector;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [27:0] corr_dat;
    logic        corr_vld;
    logic        all_zeros;
    logic        det_vld;
    logic [1:0]  det_bank;
    logic [6:0]  det_score;
    logic [2:0]  det_offset;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int det_cnt = 0;
    int det_cyc = -1;
    int last_s_cyc = 0;

    preamble_peak_detector #(
        .LENGTH      (64),
        .BANKS       (4),
        .THRESHOLD   (52),
        .PEAK_WINDOW (4),
        .HOLDOFF     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .corr_dat   (corr_dat),
        .corr_vld   (corr_vld),
        .all_zeros  (all_zeros),
        .det_vld    (det_vld),
        .det_bank   (det_bank),
        .det_score  (det_score),
        .det_offset (det_offset),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (det_vld === 1'b1) begin
            det_cnt = det_cnt + 1;
            det_cyc = cyc;
        end
    end

    // Called at a negedge; presents one sample for one cycle then idles gap cycles.
    task automatic send(input logic [6:0] b0, input logic [6:0] b1, input logic [6:0] b2,
                        input logic [6:0] b3, input int gap);
        corr_dat   = {b3, b2, b1, b0};
        corr_vld   = 1'b1;
        last_s_cyc = cyc;
        @(negedge clk);
        corr_vld = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_b2(input logic [6:0] s, input int gap);
        send(7'd10, 7'd10, s, 7'd10, gap);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        corr_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            corr_dat = {4{7'd60}};
            corr_vld = (i == 0);
            @(negedge clk);
            checks++; if (det_vld !== 1'b0) begin errors++; $display("FAIL reset_det_vld got %b want 0", det_vld); end
            checks++; if (det_bank !== 2'd0) begin errors++; $display("FAIL reset_det_bank got %0d want 0", det_bank); end
            checks++; if (det_score !== 7'd0) begin errors++; $display("FAIL reset_det_score got %0d want 0", det_score); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        end
        rst      = 1'b0;
        corr_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (det_vld !== 1'b0) begin errors++; $display("FAIL post_reset_det_vld got %b want 0", det_vld); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy); end
            checks++; if (det_offset !== 3'd0) begin errors++; $display("FAIL post_reset_det_offset got %0d want 0", det_offset); end
        end
    endtask

    task automatic test_single_peak(input int gap, input string name);
        int base;
        int s;
        do_reset();
        en = 1'b1; all_zeros = 1'b1;
        base = det_cnt;
        send_b2(7'd50, gap);
        send_b2(7'd53, gap);
        send_b2(7'd58, gap);
        send_b2(7'd55, gap);
        send_b2(7'd54, gap);
        send_b2(7'd53, gap);
        send_b2(7'd52, gap);
        s = last_s_cyc;
        repeat (4) @(negedge clk);
        checks++; if (det_cnt - base !== 1) begin errors++; $display("FAIL %s_pulses got %0d want 1", name, det_cnt - base); end
        checks++; if (det_cyc !== s + 2) begin errors++; $display("FAIL %s_latency got cyc %0d want %0d", name, det_cyc, s + 2); end
        checks++; if (det_bank !== 2'd2) begin errors++; $display("FAIL %s_bank got %0d want 2", name, det_bank); end
        checks++; if (det_score !== 7'd58) begin errors++; $display("FAIL %s_score got %0d want 58", name, det_score); end
        checks++; if (det_offset !== 3'd4) begin errors++; $display("FAIL %s_offset got %0d want 4", name, det_offset); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_hold got %b want 1", name, busy); end
    endtask

    task automatic test_tie();
        int base;
        int s4;
        do_reset();
        base = det_cnt;
        send(7'd0, 7'd0, 7'd0, 7'd0, 0);
        send(7'd10, 7'd60, 7'd10, 7'd60, 0);
        send(7'd10, 7'd60, 7'd10, 7'd60, 0);
        send(7'd10, 7'd59, 7'd10, 7'd59, 0);
        send(7'd10, 7'd59, 7'd10, 7'd59, 0);
        send(7'd10, 7'd59, 7'd10, 7'd59, 0);
        s4 = last_s_cyc;
        send(7'd10, 7'd59, 7'd10, 7'd59, 0);
        repeat (4) @(negedge clk);
        checks++; if (det_cnt - base !== 1) begin errors++; $display("FAIL tie_pulses got %0d want 1", det_cnt - base); end
        checks++; if (det_cyc !== s4 + 2) begin errors++; $display("FAIL tie_latency got cyc %0d want %0d", det_cyc, s4 + 2); end
        checks++; if (det_bank !== 2'd1) begin errors++; $display("FAIL tie_bank got %0d want 1", det_bank); end
        checks++; if (det_score !== 7'd60) begin errors++; $display("FAIL tie_score got %0d want 60", det_score); end
    endtask

    task automatic test_holdoff();
        int base;
        int s;
        do_reset();
        all_zeros = 1'b1;
        base = det_cnt;
        send_b2(7'd50, 0); send_b2(7'd53, 0); send_b2(7'd58, 0); send_b2(7'd55, 0);
        send_b2(7'd54, 0); send_b2(7'd53, 0); send_b2(7'd52, 0);
        repeat (3) @(negedge clk);
        checks++; if (det_cnt - base !== 1) begin errors++; $display("FAIL hold_first_pulses got %0d want 1", det_cnt - base); end
        all_zeros = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) send(7'd63, 7'd10, 7'd10, 7'd10, 1);
            else        send(7'd10, 7'd10, 7'd10, 7'd10, 1);
            if (i == 6) begin
                repeat (2) @(negedge clk);
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy_before_end got %b want 1", busy); end
            end
        end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy_after_end got %b want 0", busy); end
        checks++; if (det_cnt - base !== 1) begin errors++; $display("FAIL hold_ignored_peak got %0d pulses want 1", det_cnt - base); end
        checks++; if (det_score !== 7'd58) begin errors++; $display("FAIL hold_score_kept got %0d want 58", det_score); end
        for (int i = 0; i < 8; i++) begin
            if (i == 1) send(7'd63, 7'd10, 7'd10, 7'd10, 1);
            else        send(7'd40, 7'd10, 7'd10, 7'd10, 1);
        end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noisy_idle_busy got %b want 0", busy); end
        checks++; if (det_cnt - base !== 1) begin errors++; $display("FAIL noisy_idle_pulses got %0d want 1", det_cnt - base); end
        all_zeros = 1'b1;
        send(7'd10, 7'd10, 7'd10, 7'd10, 0);
        send(7'd10, 7'd10, 7'd10, 7'd57, 0);
        send(7'd10, 7'd10, 7'd10, 7'd50, 0);
        send(7'd10, 7'd10, 7'd10, 7'd50, 0);
        send(7'd10, 7'd10, 7'd10, 7'd50, 0);
        send(7'd10, 7'd10, 7'd10, 7'd50, 0);
        s = last_s_cyc;
        repeat (4) @(negedge clk);
        checks++; if (det_cnt - base !== 2) begin errors++; $display("FAIL rearm_pulses got %0d want 2", det_cnt - base); end
        checks++; if (det_cyc !== s + 2) begin errors++; $display("FAIL rearm_latency got cyc %0d want %0d", det_cyc, s + 2); end
        checks++; if (det_score !== 7'd57) begin errors++; $display("FAIL rearm_score got %0d want 57", det_score); end
        checks++; if (det_bank !== 2'd3) begin errors++; $display("FAIL rearm_bank got %0d want 3", det_bank); end
    endtask

    task automatic test_abort();
        int base;
        int s;
        do_reset();
        en = 1'b1; all_zeros = 1'b1;
        base = det_cnt;
        send_b2(7'd50, 0); send_b2(7'd53, 0); send_b2(7'd50, 0); send_b2(7'd50, 0);
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_track got %b want 1", busy); end
        en = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_drop got %b want 0", busy); end
        send_b2(7'd50, 1); send_b2(7'd50, 1);
        repeat (3) @(negedge clk);
        checks++; if (det_cnt - base !== 0) begin errors++; $display("FAIL abort_no_det got %0d pulses want 0", det_cnt - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_idle got %b want 0", busy); end

        en = 1'b1;
        send_b2(7'd10, 0); send_b2(7'd55, 0);
        send_b2(7'd40, 0); send_b2(7'd40, 0); send_b2(7'd40, 0); send_b2(7'd40, 0);
        s = last_s_cyc;
        repeat (4) @(negedge clk);
        checks++; if (det_cnt - base !== 1) begin errors++; $display("FAIL resume_pulses got %0d want 1", det_cnt - base); end
        checks++; if (det_cyc !== s + 2) begin errors++; $display("FAIL resume_latency got cyc %0d want %0d", det_cyc, s + 2); end
        checks++; if (det_score !== 7'd55) begin errors++; $display("FAIL resume_score got %0d want 55", det_score); end

        // Disable lands exactly on the cycle the confirming sample reaches the FSM.
        do_reset();
        base = det_cnt;
        send_b2(7'd10, 0); send_b2(7'd61, 0);
        send_b2(7'd40, 0); send_b2(7'd40, 0); send_b2(7'd40, 0); send_b2(7'd40, 0);
        en = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (det_cnt - base !== 0) begin errors++; $display("FAIL en_override_det got %0d pulses want 0", det_cnt - base); end
        checks++; if (det_score !== 7'd0) begin errors++; $display("FAIL en_override_score got %0d want 0", det_score); end
        en = 1'b1;

        send_b2(7'd10, 0); send_b2(7'd53, 0); send_b2(7'd50, 0);
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_abort_busy_track got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_abort_busy got %b want 0", busy); end
        send_b2(7'd50, 1); send_b2(7'd50, 1); send_b2(7'd50, 1);
        repeat (3) @(negedge clk);
        checks++; if (det_cnt - base !== 0) begin errors++; $display("FAIL rst_abort_no_det got %0d pulses want 0", det_cnt - base); end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        all_zeros = 1'b1;
        corr_vld  = 1'b0;
        corr_dat  = '0;
        @(negedge clk);
        test_reset();
        test_single_peak(0, "single_peak");
        test_tie();
        test_holdoff();
        test_single_peak(5, "vld_gaps");
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
